uart_test_top: RTL and testbench
================================

Name: uart_test_top

Overview:
- Top-level UART echo (loopback) block for board bring-up.
- Receives 8N1 serial frames on uart_rx and retransmits each correctly framed byte unchanged on uart_tx.
- Contains a baud-rate timer, a receiver FSM, a one-byte holding buffer and a transmitter FSM, all in a single clock domain.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz (20 ns period).
- BAUD_RATE, 9600, serial bit rate; one bit time is about 104 us.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (5208), clocks per bit. Derived localparam, integer division.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- uart_rx  input  1  asynchronous serial input; idle high.
- uart_tx  output  1  serial output; idle high.

Behaviour:
- Frame format, both directions: 8N1.
  - 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1).
  - No parity.
- Reset (rst=0 sampled at a clk edge):
  - All FSMs go to IDLE; counters and the buffer are cleared.
  - uart_tx=1 from the next edge.
  - Reset mid-frame aborts both RX and TX immediately; any partial byte is lost.
- RX synchroniser: uart_rx passes through a 2-flop synchroniser (reset value 1) before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synchronised rx=0, go to START and clear the counter.
  - START: wait CLKS_PER_BIT/2 clocks, then resample. If 0, go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT clocks (mid-bit), shift the sample into bit[index]. After index 7, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample the line.
    - If 1: pulse rx_valid for one cycle with rx_byte, then go to IDLE.
    - If 0 (framing error): discard the byte, then wait in IDLE until the line returns to 1 before accepting a new start.
- Holding buffer: one byte plus a full flag.
  - rx_valid while the buffer is empty: load the byte and set full.
  - rx_valid while the buffer is full: drop the new byte (overrun); the existing byte is kept.
  - rx_valid and TX taking the buffer in the same cycle: the old byte goes to TX and the new byte loads; full stays 1.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If the buffer is full, latch the byte, clear full, and go to START on the next edge.
  - START: drive 0 for CLKS_PER_BIT clocks.
  - DATA: drive bits 0..7, each for CLKS_PER_BIT clocks.
  - STOP: drive 1 for CLKS_PER_BIT clocks, then return to IDLE.
  - Back-to-back bytes leave no extra idle time beyond the stop bit.
- uart_tx is driven from a register (no combinational glitches).
- Latency: the echo start-bit falling edge occurs no more than 4 clocks after the RX stop-bit mid-sample, provided TX is idle.
- Counters are wide enough for CLKS_PER_BIT-1 (13 bits at the defaults).
- Echo is a pure pass-through: no byte transformation.

Test Plan:
- Reset: hold rst=0 for 1+ clocks, uart_rx=1 -> uart_tx=1 throughout; it stays 1 after release with no input.
- Single byte: after reset release, send 0x49 at 9600 baud (bits LSB first: start 0, 1,0,0,1,0,0,1,0, stop 1; 104 us per bit) -> uart_tx starts its start bit about 9.5 bit times after the rx falling edge and emits 0x49 with correct 104 us bit widths, then idles high.
- Back-to-back: send 0x00, 0xFF, 0xA5 with no gaps -> uart_tx echoes 0x00, 0xFF, 0xA5 in order, with no lost byte and valid stop bits.
- Glitch: pulse uart_rx low for 1 us -> no RX byte, and uart_tx stays 1.
- Framing error: send 0x49 with the stop bit 0, then hold the line high and send 0x3C -> only 0x3C is echoed.
- Reset mid-operation: assert rst during the echo's data bits -> uart_tx=1 on the next edge; a subsequently sent 0x55 is echoed correctly.

Source files
------------

// File: rtl/uart_test_top.sv
// rtl/uart_test_top.sv - 8N1 UART echo: synchroniser, RX FSM, one-byte holding buffer, TX FSM
module uart_test_top #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    output logic uart_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          r_rx_meta;
    logic          r_rx_sync;

    state_t        r_rx_state, w_rx_state_nxt;
    logic [CW-1:0] r_rx_cnt,   w_rx_cnt_nxt;
    logic [2:0]    r_rx_idx,   w_rx_idx_nxt;
    logic [7:0]    r_rx_shift, w_rx_shift_nxt;
    logic          r_rx_brk,   w_rx_brk_nxt;
    logic          r_rx_valid, w_rx_valid_nxt;

    logic [7:0]    r_buf_data;
    logic          r_buf_full;

    state_t        r_tx_state, w_tx_state_nxt;
    logic [CW-1:0] r_tx_cnt,   w_tx_cnt_nxt;
    logic [2:0]    r_tx_idx,   w_tx_idx_nxt;
    logic [7:0]    r_tx_shift, w_tx_shift_nxt;
    logic          w_tx_take;
    logic          w_tx_bit;
    logic          r_tx;

    assign uart_tx = r_tx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_brk   <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_brk   <= w_rx_brk_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    // r_rx_brk blocks new starts after a framing error until the line is seen high
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_brk_nxt   = r_rx_brk;
        w_rx_valid_nxt = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (r_rx_sync) begin
                    w_rx_brk_nxt = 1'b0;
                end else if (!r_rx_brk) begin
                    w_rx_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_idx_nxt   = '0;
                    w_rx_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nxt             = '0;
                    w_rx_shift_nxt[r_rx_idx] = r_rx_sync;
                    if (r_rx_idx == 3'd7) begin
                        w_rx_state_nxt = S_STOP;
                    end else begin
                        w_rx_idx_nxt = r_rx_idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = S_IDLE;
                    if (r_rx_sync) begin
                        w_rx_valid_nxt = 1'b1;
                    end else begin
                        w_rx_brk_nxt = 1'b1;
                    end
                end
            end
            default: w_rx_state_nxt = S_IDLE;
        endcase
    end

    // A byte arriving while full is dropped unless TX empties the buffer this cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf_data <= '0;
            r_buf_full <= 1'b0;
        end else if (r_rx_valid && (!r_buf_full || w_tx_take)) begin
            r_buf_data <= r_rx_shift;
            r_buf_full <= 1'b1;
        end else if (w_tx_take) begin
            r_buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_bit;
        end
    end

    // Chaining straight from STOP to START keeps back-to-back frames gapless
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_take      = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (r_buf_full) begin
                    w_tx_take      = 1'b1;
                    w_tx_shift_nxt = r_buf_data;
                    w_tx_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_idx_nxt   = '0;
                    w_tx_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_state_nxt = S_STOP;
                    end else begin
                        w_tx_idx_nxt = r_tx_idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_buf_full) begin
                        w_tx_take      = 1'b1;
                        w_tx_shift_nxt = r_buf_data;
                        w_tx_state_nxt = S_START;
                    end else begin
                        w_tx_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_tx_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_bit = 1'b1;
        case (r_tx_state)
            S_IDLE:  w_tx_bit = 1'b1;
            S_START: w_tx_bit = 1'b0;
            S_DATA:  w_tx_bit = r_tx_shift[r_tx_idx];
            S_STOP:  w_tx_bit = 1'b1;
            default: w_tx_bit = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_test_top.sv
// tb/tb_uart_test_top.sv - scoreboard bench for the UART echo at 16 clocks per bit
module tb_uart_test_top;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int  mon_bit     = -1;
    bit  mon_en      = 1'b0;
    bit  mon_discard = 1'b0;
    int  tx_fall_cyc = 0;
    int  rx_fall_cyc = 0;
    bit  idle_bad    = 1'b0;

    uart_test_top #(.CLK_FREQ(100000000), .BAUD_RATE(6250000)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit expect_echo);
        @(posedge clk); #1;
        if (expect_echo) exp_q.push_back(d);
        uart_rx = 1'b0;
        rx_fall_cyc = cyc;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
        uart_rx = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_bit != -1) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done"}, (n < 2000) ? 1 : 0, 1);
        repeat (20) @(posedge clk);
    endtask

    // Monitor: decode uart_tx frames at mid-bit and score them against exp_q
    initial begin
        logic [7:0] got;
        logic prev;
        bit aborted;
        prev = 1'b1;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && uart_tx === 1'b0) begin
                tx_fall_cyc = cyc;
                mon_bit = 0;
                aborted = 1'b0;
                repeat (CPB/2 - 1) @(negedge clk);
                if (mon_discard) aborted = 1'b1;
                else check("tx_start_bit", int'(uart_tx), 0);
                for (int i = 0; i < 8 && !aborted; i++) begin
                    repeat (CPB) @(negedge clk);
                    if (mon_discard) aborted = 1'b1;
                    else begin
                        got[i] = uart_tx;
                        mon_bit = i + 1;
                    end
                end
                if (!aborted) begin
                    repeat (CPB) @(negedge clk);
                    if (mon_discard) aborted = 1'b1;
                end
                if (aborted) begin
                    mon_discard = 1'b0;
                end else begin
                    check("tx_stop_bit", int'(uart_tx), 1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", got);
                    end else begin
                        check("echo_byte", int'(got), int'(exp_q.pop_front()));
                    end
                end
                mon_bit = -1;
            end
            prev = uart_tx;
        end
    end

    initial begin
        int n;
        int lat;

        // Reset: line idle, output must be high during and after reset
        rst = 1'b0;
        uart_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx", int'(uart_tx), 1);
        mon_en = 1'b1;
        rst = 1'b1;
        idle_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) idle_bad = 1'b1;
        end
        check("idle_after_reset", int'(idle_bad), 0);

        // Single byte with latency of roughly 9.5 bit times
        send_frame(8'h49, 1'b1, 1'b1);
        wait_done("single");
        lat = tx_fall_cyc - rx_fall_cyc;
        check("latency_in_range", (lat >= 150 && lat <= 162) ? 1 : 0, 1);

        // Back-to-back frames
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_done("b2b");

        // Short glitch must not produce a byte
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        idle_bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) idle_bad = 1'b1;
        end
        check("glitch_tx_idle", int'(idle_bad), 0);

        // Framing error then a good byte
        send_frame(8'h49, 1'b0, 1'b0);
        repeat (3 * CPB) @(posedge clk);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_done("framing");

        // Reset during the echo's data bits, then a clean byte
        send_frame(8'h5A, 1'b1, 1'b1);
        n = 0;
        while (mon_bit < 3 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("reach_tx_data", (n < 1000) ? 1 : 0, 1);
        #1;
        mon_discard = 1'b1;
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        check("tx_high_after_reset", int'(uart_tx), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        mon_discard = 1'b0;
        send_frame(8'h55, 1'b1, 1'b1);
        wait_done("post_reset");

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
